// File: rtl/genius_pkg.sv
// rtl/genius_pkg.sv - shared colour codes, player states and LED decode for the Genius sequence player
// Purpose: constants and helpers imported by genius_seq_player and genius_timer.
// Contents: colour codes, player state encoding, onehot() colour-to-lamp decode.
package genius_pkg;

  localparam logic [1:0] COL_GREEN = 2'd0;
  localparam logic [1:0] COL_RED   = 2'd1;
  localparam logic [1:0] COL_BLUE  = 2'd2;
  localparam logic [1:0] COL_NONE  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ON    = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Bit i of the lamp pattern drives the LED beside button i; the
  // unused code lights nothing so a corrupt RAM word stays dark.
  function automatic logic [2:0] onehot(input logic [1:0] code);
    logic [2:0] pat;
    case (code)
      COL_GREEN: pat = 3'b001;
      COL_RED:   pat = 3'b010;
      COL_BLUE:  pat = 3'b100;
      default:   pat = 3'b000;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/genius_timer.sv
// rtl/genius_timer.sv - loadable down-counter used for the LED on and gap intervals
// Purpose: holds a cycle count that decrements to zero and stays there.
// Ports: clock, reset (sync, active-high), load (take value), value (count to load),
//        expired (count is zero).
module genius_timer #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  // Loading T-1 and leaving on zero gives an interval of exactly T cycles.
  assign expired = (count == '0);

endmodule

// File: rtl/genius_seq_player.sv
// rtl/genius_seq_player.sv - plays the stored Genius colour sequence on the three game LEDs
// Purpose: on start, steps through len_q RAM entries, lighting each colour for
//          T_on cycles followed by T_gap dark cycles, then pulses done.
// Ports: clock, reset (sync, active-high), start, length, speed (on/gap shift),
//        seq_addr/seq_data (synchronous RAM, 1-cycle read), leds (one-hot lamp),
//        busy (not idle), done (end-of-playback pulse).
module genius_seq_player
  import genius_pkg::*;
#(
  parameter int MAX_LEN    = 16,
  parameter int ON_CYCLES  = 25000000,
  parameter int GAP_CYCLES = 12500000,
  parameter int ADDR_W     = $clog2(MAX_LEN)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   length,
  input  logic [1:0]        speed,
  output logic [ADDR_W-1:0] seq_addr,
  input  logic [1:0]        seq_data,
  output logic [2:0]        leds,
  output logic              busy,
  output logic              done
);

  localparam int CNT_MAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [ADDR_W:0]  MAX_LEN_V = (ADDR_W + 1)'(MAX_LEN);
  localparam logic [CNT_W-1:0] ON_V      = CNT_W'(ON_CYCLES);
  localparam logic [CNT_W-1:0] GAP_V     = CNT_W'(GAP_CYCLES);

  state_e            state;
  logic [ADDR_W:0]   len_q;
  logic [1:0]        spd_q;
  logic [ADDR_W-1:0] step;
  logic [1:0]        col_q;

  logic [CNT_W-1:0]  on_shift;
  logic [CNT_W-1:0]  gap_shift;
  logic [CNT_W-1:0]  on_load;
  logic [CNT_W-1:0]  gap_load;
  logic [CNT_W-1:0]  tmr_value;
  logic              tmr_load;
  logic              tmr_expired;
  logic              last_step;

  // Interval lengths saturate at one cycle, so the loaded value is max(T,1)-1.
  always_comb begin
    on_shift  = ON_V >> spd_q;
    gap_shift = GAP_V >> spd_q;
    on_load   = (on_shift == '0) ? '0 : on_shift - CNT_W'(1);
    gap_load  = (gap_shift == '0) ? '0 : gap_shift - CNT_W'(1);
  end

  assign last_step = ({1'b0, step} == (len_q - (ADDR_W + 1)'(1)));

  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = on_load;
    if (state == ST_FETCH) begin
      tmr_load  = 1'b1;
      tmr_value = on_load;
    end else if (state == ST_ON && tmr_expired) begin
      tmr_load  = 1'b1;
      tmr_value = gap_load;
    end
  end

  genius_timer #(
    .W(CNT_W)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .load    (tmr_load),
    .value   (tmr_value),
    .expired (tmr_expired)
  );

  // The RAM registers its address, so the address for a step is presented
  // on the cycle that enters FETCH; data is then valid during FETCH and is
  // captured into col_q on the FETCH->ON edge. Step is 0 in IDLE, which
  // covers the first fetch.
  always_comb begin
    if (state == ST_GAP && tmr_expired && !last_step) begin
      seq_addr = step + ADDR_W'(1);
    end else begin
      seq_addr = step;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      len_q <= '0;
      spd_q <= '0;
      step  <= '0;
      col_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            len_q <= (length > MAX_LEN_V) ? MAX_LEN_V : length;
            spd_q <= speed;
            step  <= '0;
            state <= (length == '0) ? ST_DONE : ST_FETCH;
          end
        end
        ST_FETCH: begin
          col_q <= seq_data;
          state <= ST_ON;
        end
        ST_ON: begin
          if (tmr_expired) begin
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (tmr_expired) begin
            if (last_step) begin
              step  <= '0;
              state <= ST_DONE;
            end else begin
              step  <= step + ADDR_W'(1);
              state <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign leds = (state == ST_ON) ? onehot(col_q) : 3'b000;
  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_genius_seq_player.sv
// tb/tb_genius_seq_player.sv - directed self-checking bench for genius_seq_player
module tb_genius_seq_player;

  logic       clock;
  logic       reset;
  logic       start;
  logic [4:0] length;
  logic [1:0] speed;
  logic [3:0] seq_addr;
  logic [1:0] seq_data;
  logic [2:0] leds;
  logic       busy;
  logic       done;

  logic [1:0] mem [0:15];

  logic [2:0] lg_leds [0:63];
  logic       lg_busy [0:63];
  logic       lg_done [0:63];
  logic [3:0] lg_addr [0:63];

  int checks;
  int errors;

  genius_seq_player #(
    .MAX_LEN    (16),
    .ON_CYCLES  (8),
    .GAP_CYCLES (4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .length   (length),
    .speed    (speed),
    .seq_addr (seq_addr),
    .seq_data (seq_data),
    .leds     (leds),
    .busy     (busy),
    .done     (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous RAM: one-cycle read latency.
  always @(posedge clock) seq_data <= mem[seq_addr];

  function automatic logic [2:0] basic_leds(input int k);
    if (k >= 2 && k <= 9) return 3'b001;
    if (k >= 15 && k <= 22) return 3'b100;
    if (k >= 28 && k <= 35) return 3'b010;
    return 3'b000;
  endfunction

  function automatic logic [2:0] exp_lamp(input logic [1:0] c);
    if (c == 2'd0) return 3'b001;
    if (c == 2'd1) return 3'b010;
    if (c == 2'd2) return 3'b100;
    return 3'b000;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Presents start before edge 0; cycle k is the period that follows edge k-1.
  task automatic launch(input logic [4:0] len, input logic [1:0] spd);
    @(negedge clock);
    length = len;
    speed  = spd;
    start  = 1'b1;
    @(posedge clock);
  endtask

  task automatic capture(input int n, input int rst_cyc, input int p1, input int p2, input bit hold);
    for (int k = 1; k <= n; k++) begin
      @(negedge clock);
      lg_leds[k] = leds;
      lg_busy[k] = busy;
      lg_done[k] = done;
      lg_addr[k] = seq_addr;
      start = hold || (k == p1) || (k == p2);
      reset = (k == rst_cyc);
      if (k == 1) begin
        length = 5'd7;
        speed  = 2'd3;
      end
    end
    reset = 1'b0;
  endtask

  task automatic load_basic_mem();
    for (int i = 0; i < 16; i++) mem[i] = 2'd0;
    mem[0] = 2'd0;
    mem[1] = 2'd2;
    mem[2] = 2'd1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clock);
    checks++;
    if (leds !== 3'b000 || busy !== 1'b0 || done !== 1'b0 || seq_addr !== 4'd0) begin
      errors++;
      $display("FAIL reset_state leds=%b busy=%b done=%b addr=%0d expected 000/0/0/0",
               leds, busy, done, seq_addr);
    end
  endtask

  task automatic test_basic();
    do_reset();
    load_basic_mem();
    launch(5'd3, 2'd0);
    capture(45, -1, -1, -1, 1'b0);
    for (int k = 1; k <= 45; k++) begin
      checks++;
      if (lg_leds[k] !== basic_leds(k) || lg_busy[k] !== (k <= 40) || lg_done[k] !== (k == 40)) begin
        errors++;
        $display("FAIL basic cyc=%0d leds=%b busy=%b done=%b expected %b/%b/%b",
                 k, lg_leds[k], lg_busy[k], lg_done[k], basic_leds(k), (k <= 40), (k == 40));
      end
    end
  endtask

  task automatic test_speed();
    do_reset();
    load_basic_mem();
    launch(5'd2, 2'd2);
    capture(12, -1, -1, -1, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      logic [2:0] el;
      el = (k == 2 || k == 3) ? 3'b001 : (k == 6 || k == 7) ? 3'b100 : 3'b000;
      checks++;
      if (lg_leds[k] !== el || lg_done[k] !== (k == 9) || lg_busy[k] !== (k <= 9)) begin
        errors++;
        $display("FAIL speed cyc=%0d leds=%b done=%b busy=%b expected %b/%b/%b",
                 k, lg_leds[k], lg_done[k], lg_busy[k], el, (k == 9), (k <= 9));
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    load_basic_mem();
    mem[0] = 2'd1;
    launch(5'd1, 2'd3);
    capture(6, -1, -1, -1, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      logic [2:0] el;
      el = (k == 2) ? 3'b010 : 3'b000;
      checks++;
      if (lg_leds[k] !== el || lg_done[k] !== (k == 4)) begin
        errors++;
        $display("FAIL saturation cyc=%0d leds=%b done=%b expected %b/%b",
                 k, lg_leds[k], lg_done[k], el, (k == 4));
      end
    end
  endtask

  task automatic test_empty();
    do_reset();
    load_basic_mem();
    launch(5'd0, 2'd0);
    capture(6, -1, -1, -1, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      checks++;
      if (lg_leds[k] !== 3'b000 || lg_done[k] !== (k == 1) || lg_busy[k] !== (k == 1) || lg_addr[k] !== 4'd0) begin
        errors++;
        $display("FAIL empty cyc=%0d leds=%b done=%b busy=%b addr=%0d expected 000/%b/%b/0",
                 k, lg_leds[k], lg_done[k], lg_busy[k], lg_addr[k], (k == 1), (k == 1));
      end
    end
  endtask

  task automatic test_clamp_illegal();
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = 2'(i % 3);
    mem[5] = 2'd3;
    launch(5'd20, 2'd3);
    capture(52, -1, -1, -1, 1'b0);
    for (int s = 0; s < 16; s++) begin
      checks++;
      if (lg_addr[1 + 3 * s] !== 4'(s) || lg_leds[2 + 3 * s] !== exp_lamp(mem[s]) || lg_leds[3 + 3 * s] !== 3'b000) begin
        errors++;
        $display("FAIL clamp step=%0d addr=%0d on=%b gap=%b expected %0d/%b/000",
                 s, lg_addr[1 + 3 * s], lg_leds[2 + 3 * s], lg_leds[3 + 3 * s], s, exp_lamp(mem[s]));
      end
    end
    checks++;
    if (lg_done[48] !== 1'b0 || lg_done[49] !== 1'b1 || lg_busy[49] !== 1'b1 || lg_busy[50] !== 1'b0) begin
      errors++;
      $display("FAIL clamp_end done48=%b done49=%b busy49=%b busy50=%b expected 0/1/1/0",
               lg_done[48], lg_done[49], lg_busy[49], lg_busy[50]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_basic_mem();
    launch(5'd3, 2'd0);
    capture(30, 20, -1, -1, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      logic [2:0] el;
      logic       eb;
      el = (k <= 20) ? basic_leds(k) : 3'b000;
      eb = (k <= 20);
      checks++;
      if (lg_leds[k] !== el || lg_busy[k] !== eb || lg_done[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid cyc=%0d leds=%b busy=%b done=%b expected %b/%b/0",
                 k, lg_leds[k], lg_busy[k], lg_done[k], el, eb);
      end
    end
    launch(5'd3, 2'd0);
    capture(45, -1, -1, -1, 1'b0);
    for (int k = 1; k <= 45; k++) begin
      checks++;
      if (lg_leds[k] !== basic_leds(k) || lg_busy[k] !== (k <= 40) || lg_done[k] !== (k == 40)) begin
        errors++;
        $display("FAIL restart cyc=%0d leds=%b busy=%b done=%b expected %b/%b/%b",
                 k, lg_leds[k], lg_busy[k], lg_done[k], basic_leds(k), (k <= 40), (k == 40));
      end
    end
  endtask

  task automatic test_start_while_busy();
    do_reset();
    load_basic_mem();
    launch(5'd3, 2'd0);
    capture(50, -1, 5, 40, 1'b0);
    for (int k = 1; k <= 50; k++) begin
      checks++;
      if (lg_leds[k] !== basic_leds(k) || lg_busy[k] !== (k <= 40) || lg_done[k] !== (k == 40)) begin
        errors++;
        $display("FAIL start_busy cyc=%0d leds=%b busy=%b done=%b expected %b/%b/%b",
                 k, lg_leds[k], lg_busy[k], lg_done[k], basic_leds(k), (k <= 40), (k == 40));
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    load_basic_mem();
    launch(5'd3, 2'd0);
    capture(45, -1, -1, -1, 1'b1);
    checks++;
    if (lg_done[40] !== 1'b1 || lg_busy[41] !== 1'b0 || lg_done[41] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end done40=%b busy41=%b done41=%b expected 1/0/0",
               lg_done[40], lg_busy[41], lg_done[41]);
    end
    checks++;
    if (lg_busy[42] !== 1'b1 || lg_addr[42] !== 4'd0 || lg_leds[42] !== 3'b000 || lg_leds[43] !== 3'b001) begin
      errors++;
      $display("FAIL b2b_refetch busy42=%b addr42=%0d leds42=%b leds43=%b expected 1/0/000/001",
               lg_busy[42], lg_addr[42], lg_leds[42], lg_leds[43]);
    end
    start = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    start  = 1'b0;
    length = '0;
    speed  = '0;
    for (int i = 0; i < 16; i++) mem[i] = 2'd0;
    repeat (2) @(posedge clock);
    test_reset();
    test_basic();
    test_speed();
    test_saturation();
    test_empty();
    test_clamp_illegal();
    test_reset_mid();
    test_start_while_busy();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
